// File: rtl/tcp_timer_bank.sv
// tcp_timer_bank: NUM_CH countdown timers on a shared tick with a round-robin expiry event port.
// Optional feature: define TIMER_BACKOFF_EN for exponential backoff with a retry limit on periodic channels.
module tcp_timer_bank #(
  parameter  int NUM_CH    = 8,
  parameter  int CNT_W     = 16,
  parameter  int MAX_RETRY = 6,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              i_sys_clk,
  input  logic              i_rst,
  input  logic              i_tick,
  input  logic              i_start_vld,
  input  logic [CH_W-1:0]   i_start_ch,
  input  logic [CNT_W-1:0]  i_start_val,
  input  logic              i_start_per,
  input  logic              i_stop_vld,
  input  logic [CH_W-1:0]   i_stop_ch,
  output logic [NUM_CH-1:0] o_busy,
  output logic [NUM_CH-1:0] o_timeout,
  output logic [NUM_CH-1:0] o_ovf,
  output logic              o_evt_vld,
  output logic [CH_W-1:0]   o_evt_ch,
  input  logic              i_evt_rdy,
  output logic [NUM_CH-1:0] o_giveup
);

  logic [NUM_CH-1:0] busy_q, per_q, pend_q, ovf_q, tmo_q;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  rld_q [NUM_CH];
  logic              evt_vld_q;
  logic [CH_W-1:0]   evt_ch_q, rr_q;

  logic [NUM_CH-1:0] start_hit, stop_hit, exp_hit, ack_hit, pend_rem;
  logic [CNT_W-1:0]  start_cnt;
  logic [CH_W-1:0]   rr_next, ptr_sel;
  logic              ack, evt_refresh;

  // First pending channel at or after ptr, wrapping around.
  function automatic logic [CH_W-1:0] pick(input logic [NUM_CH-1:0] p, input logic [CH_W-1:0] ptr);
    logic found;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      int idx;
      idx = (int'(ptr) + k) % NUM_CH;
      if (!found && p[idx]) begin
        pick  = CH_W'(idx);
        found = 1'b1;
      end
    end
  endfunction

  // NOTE: every signal is assigned on every pass through always_comb, so no latch is inferred.
  always_comb begin
    ack       = evt_vld_q & i_evt_rdy;
    start_cnt = (i_start_val == '0) ? CNT_W'(1) : i_start_val;
    for (int i = 0; i < NUM_CH; i++) begin
      start_hit[i] = i_start_vld && (i_start_ch == CH_W'(i));
      stop_hit[i]  = i_stop_vld && (i_stop_ch == CH_W'(i)) && !start_hit[i];
      exp_hit[i]   = busy_q[i] && i_tick && (cnt_q[i] == CNT_W'(1)) && !start_hit[i] && !stop_hit[i];
      ack_hit[i]   = ack && (evt_ch_q == CH_W'(i));
    end
    pend_rem    = pend_q & ~ack_hit;
    rr_next     = (evt_ch_q == CH_W'(NUM_CH - 1)) ? '0 : evt_ch_q + CH_W'(1);
    ptr_sel     = ack ? rr_next : rr_q;
    // Re-arbitrate when idle, on acceptance, or when a stop withdrew the presented event.
    evt_refresh = !evt_vld_q || ack || !pend_q[evt_ch_q];
  end

`ifdef TIMER_BACKOFF_EN
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  logic [RETRY_W-1:0] retry_q [NUM_CH];
  logic [NUM_CH-1:0]  give_hit, giveup_q;
  logic [CNT_W-1:0]   dbl [NUM_CH];

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      give_hit[i] = exp_hit[i] && per_q[i] && (retry_q[i] == RETRY_W'(MAX_RETRY - 1));
      dbl[i]      = rld_q[i][CNT_W-1] ? '1 : {rld_q[i][CNT_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      giveup_q <= '0;
      for (int i = 0; i < NUM_CH; i++) retry_q[i] <= '0;
    end else begin
      giveup_q <= give_hit;
      for (int i = 0; i < NUM_CH; i++) begin
        if (start_hit[i] || stop_hit[i])   retry_q[i] <= '0;
        else if (exp_hit[i] && per_q[i])   retry_q[i] <= retry_q[i] + RETRY_W'(1);
      end
    end
  end

  assign o_giveup = giveup_q;
`else
  logic [31:0] unused_max_retry;
  assign unused_max_retry = MAX_RETRY;
  assign o_giveup         = '0;
`endif

  // NOTE: non-blocking assignments so every channel update reads pre-edge state;
  // the counter/reload arrays are plain flops and are cleared by reset like the rest.
  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      busy_q <= '0;
      per_q  <= '0;
      pend_q <= '0;
      ovf_q  <= '0;
      tmo_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        rld_q[i] <= '0;
      end
    end else begin
      tmo_q <= exp_hit;
      for (int i = 0; i < NUM_CH; i++) begin
        if (start_hit[i]) begin
          busy_q[i] <= 1'b1;
          cnt_q[i]  <= start_cnt;
          rld_q[i]  <= start_cnt;
          per_q[i]  <= i_start_per;
        end else if (stop_hit[i]) begin
          busy_q[i] <= 1'b0;
          cnt_q[i]  <= '0;
        end else if (exp_hit[i]) begin
          if (!per_q[i]) begin
            busy_q[i] <= 1'b0;
            cnt_q[i]  <= '0;
`ifdef TIMER_BACKOFF_EN
          end else if (give_hit[i]) begin
            busy_q[i] <= 1'b0;
            cnt_q[i]  <= '0;
          end else begin
            rld_q[i] <= dbl[i];
            cnt_q[i] <= dbl[i];
`else
          end else begin
            cnt_q[i] <= rld_q[i];
`endif
          end
        end else if (busy_q[i] && i_tick) begin
          cnt_q[i] <= cnt_q[i] - CNT_W'(1);
        end

        if (stop_hit[i]) begin
          pend_q[i] <= 1'b0;
          ovf_q[i]  <= 1'b0;
        end else if (exp_hit[i]) begin
          pend_q[i] <= 1'b1;
          if (pend_q[i] && !ack_hit[i]) ovf_q[i] <= 1'b1;
        end else if (ack_hit[i]) begin
          pend_q[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      evt_vld_q <= 1'b0;
      evt_ch_q  <= '0;
      rr_q      <= '0;
    end else begin
      if (evt_refresh) begin
        evt_vld_q <= |pend_rem;
        evt_ch_q  <= pick(pend_rem, ptr_sel);
      end
      if (ack) rr_q <= rr_next;
    end
  end

  assign o_busy    = busy_q;
  assign o_timeout = tmo_q;
  assign o_ovf     = ovf_q;
  assign o_evt_vld = evt_vld_q;
  assign o_evt_ch  = evt_ch_q;

endmodule

// File: tb/tb_tcp_timer_bank.sv
// Self-checking bench for tcp_timer_bank: directed scenarios plus randomized traffic against a
// behavioural model. Follows TIMER_BACKOFF_EN the same way the design does.
module tb_tcp_timer_bank;
  localparam int N   = 8;
  localparam int W   = 8;
  localparam int MR  = 3;
  localparam int CHW = 3;
  localparam int SAT = (1 << W) - 1;

  logic           clk = 1'b0;
  logic           rst, tick, start_vld, start_per, stop_vld, evt_rdy;
  logic [CHW-1:0] start_ch, stop_ch, evt_ch;
  logic [W-1:0]   start_val;
  logic [N-1:0]   busy, timeout, ovf, giveup;
  logic           evt_vld;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tcp_timer_bank #(.NUM_CH(N), .CNT_W(W), .MAX_RETRY(MR)) dut (
    .i_sys_clk  (clk),
    .i_rst      (rst),
    .i_tick     (tick),
    .i_start_vld(start_vld),
    .i_start_ch (start_ch),
    .i_start_val(start_val),
    .i_start_per(start_per),
    .i_stop_vld (stop_vld),
    .i_stop_ch  (stop_ch),
    .o_busy     (busy),
    .o_timeout  (timeout),
    .o_ovf      (ovf),
    .o_evt_vld  (evt_vld),
    .o_evt_ch   (evt_ch),
    .i_evt_rdy  (evt_rdy),
    .o_giveup   (giveup)
  );

  // Behavioural model: remaining ticks per channel plus flag vectors.
  bit [N-1:0] m_busy, m_per, m_pend, m_ovf, m_tmo, m_give;
  int         m_left [N];
  int         m_rld  [N];
  int         m_retry[N];
  bit         m_evt_vld;
  int         m_evt_ch, m_ptr;

  task automatic model_step();
    bit [N-1:0] pend_old, avail;
    bit accept, st, sp, fire;
    int acc, base, v;
    if (rst) begin
      m_busy = '0; m_per = '0; m_pend = '0; m_ovf = '0; m_tmo = '0; m_give = '0;
      for (int c = 0; c < N; c++) begin
        m_left[c] = 0; m_rld[c] = 0; m_retry[c] = 0;
      end
      m_evt_vld = 0; m_evt_ch = 0; m_ptr = 0;
      return;
    end
    pend_old = m_pend;
    accept   = m_evt_vld && evt_rdy;
    acc      = m_evt_ch;
    m_tmo    = '0;
    m_give   = '0;
    for (int c = 0; c < N; c++) begin
      st   = start_vld && (int'(start_ch) == c);
      sp   = stop_vld && (int'(stop_ch) == c) && !st;
      fire = m_busy[c] && tick && (m_left[c] == 1) && !st && !sp;
      if (accept && acc == c) m_pend[c] = 0;
      if (st) begin
        v = (start_val == 0) ? 1 : int'(start_val);
        m_busy[c] = 1; m_left[c] = v; m_rld[c] = v; m_per[c] = start_per; m_retry[c] = 0;
      end else if (sp) begin
        m_busy[c] = 0; m_left[c] = 0; m_pend[c] = 0; m_ovf[c] = 0; m_retry[c] = 0;
      end else if (fire) begin
        m_tmo[c] = 1;
        if (pend_old[c] && !(accept && acc == c)) m_ovf[c] = 1;
        m_pend[c] = 1;
        if (!m_per[c]) begin
          m_busy[c] = 0; m_left[c] = 0;
        end else begin
`ifdef TIMER_BACKOFF_EN
          m_retry[c]++;
          if (m_retry[c] == MR) begin
            m_busy[c] = 0; m_left[c] = 0; m_give[c] = 1;
          end else begin
            m_rld[c]  = (2 * m_rld[c] > SAT) ? SAT : 2 * m_rld[c];
            m_left[c] = m_rld[c];
          end
`else
          m_left[c] = m_rld[c];
`endif
        end
      end else if (m_busy[c] && tick) begin
        m_left[c]--;
      end
    end
    if (!m_evt_vld || accept || !pend_old[m_evt_ch]) begin
      avail = pend_old;
      if (accept) avail[acc] = 0;
      base      = accept ? (acc + 1) % N : m_ptr;
      m_evt_vld = 0;
      m_evt_ch  = 0;
      for (int k = 0; k < N; k++) begin
        if (!m_evt_vld && avail[(base + k) % N]) begin
          m_evt_vld = 1;
          m_evt_ch  = (base + k) % N;
        end
      end
    end
    if (accept) m_ptr = (acc + 1) % N;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; tick = 0; start_vld = 0; stop_vld = 0; evt_rdy = 0;
    start_ch = '0; stop_ch = '0; start_val = '0; start_per = 0;
    cycle();
    rst = 0;
  endtask

  task automatic start(input int ch, input int val, input bit per);
    start_vld = 1; start_ch = CHW'(ch); start_val = W'(val); start_per = per;
  endtask

  task automatic test_reset();
    do_reset();
    cycle();
    total++; if (busy !== '0)    begin bad++; $display("FAIL reset_busy: got %h want 00", busy); end
    total++; if (timeout !== '0) begin bad++; $display("FAIL reset_timeout: got %h want 00", timeout); end
    total++; if (ovf !== '0)     begin bad++; $display("FAIL reset_ovf: got %h want 00", ovf); end
    total++; if (evt_vld !== 0)  begin bad++; $display("FAIL reset_evt_vld: got %b want 0", evt_vld); end
    total++; if (giveup !== '0)  begin bad++; $display("FAIL reset_giveup: got %h want 00", giveup); end
  endtask

  task automatic test_oneshot();
    do_reset();
    tick = 1;
    start(2, 5, 0);
    cycle();
    start_vld = 0;
    total++; if (busy !== 8'h04) begin bad++; $display("FAIL oneshot_busy: got %h want 04", busy); end
    for (int t = 1; t <= 4; t++) begin
      cycle();
      total++; if (timeout !== '0) begin bad++; $display("FAIL oneshot_early t=%0d: got %h want 00", t, timeout); end
    end
    cycle();
    total++; if (timeout !== 8'h04) begin bad++; $display("FAIL oneshot_timeout: got %h want 04", timeout); end
    total++; if (busy !== 8'h00)    begin bad++; $display("FAIL oneshot_idle: got %h want 00", busy); end
    cycle();
    total++; if (evt_vld !== 1 || evt_ch !== 3'd2)
      begin bad++; $display("FAIL oneshot_evt: got vld=%b ch=%0d want vld=1 ch=2", evt_vld, evt_ch); end
    total++; if (timeout !== '0) begin bad++; $display("FAIL oneshot_pulse_len: got %h want 00", timeout); end
    evt_rdy = 1;
    cycle();
    evt_rdy = 0;
    total++; if (evt_vld !== 0) begin bad++; $display("FAIL oneshot_drain: got %b want 0", evt_vld); end
  endtask

  task automatic test_periodic_ovf();
    do_reset();
    tick = 1;
    start(0, 3, 1);
    cycle();
    start_vld = 0;
    cycle(); cycle(); cycle();
    total++; if (timeout !== 8'h01 || ovf !== 8'h00)
      begin bad++; $display("FAIL periodic_first: got to=%h ovf=%h want to=01 ovf=00", timeout, ovf); end
    cycle();
    total++; if (evt_vld !== 1 || evt_ch !== 3'd0)
      begin bad++; $display("FAIL periodic_evt: got vld=%b ch=%0d want vld=1 ch=0", evt_vld, evt_ch); end
    cycle(); cycle();
    total++; if (timeout !== 8'h01 || ovf !== 8'h01 || busy !== 8'h01)
      begin bad++; $display("FAIL periodic_ovf: got to=%h ovf=%h busy=%h want 01 01 01", timeout, ovf, busy); end
    stop_vld = 1; stop_ch = 3'd0;
    cycle();
    stop_vld = 0;
    total++; if (busy !== '0 || ovf !== '0)
      begin bad++; $display("FAIL periodic_stop: got busy=%h ovf=%h want 00 00", busy, ovf); end
    cycle();
    total++; if (evt_vld !== 0 || timeout !== '0)
      begin bad++; $display("FAIL periodic_stop_evt: got vld=%b to=%h want 0 00", evt_vld, timeout); end
  endtask

  task automatic test_round_robin();
    int want[3] = '{1, 4, 6};
    do_reset();
    tick = 1; evt_rdy = 1;
    start(1, 5, 0); cycle();
    start(4, 4, 0); cycle();
    start(6, 3, 0); cycle();
    start_vld = 0;
    cycle(); cycle(); cycle();
    total++; if (timeout !== 8'h52) begin bad++; $display("FAIL rr_same_cycle: got %h want 52", timeout); end
    for (int k = 0; k < 3; k++) begin
      cycle();
      total++; if (evt_vld !== 1 || int'(evt_ch) != want[k])
        begin bad++; $display("FAIL rr_order k=%0d: got vld=%b ch=%0d want ch=%0d", k, evt_vld, evt_ch, want[k]); end
    end
    cycle();
    total++; if (evt_vld !== 0) begin bad++; $display("FAIL rr_empty: got %b want 0", evt_vld); end
    start(7, 3, 0); cycle();
    start(0, 2, 0); cycle();
    start_vld = 0;
    cycle(); cycle();
    total++; if (timeout !== 8'h81) begin bad++; $display("FAIL rr_wrap_to: got %h want 81", timeout); end
    cycle();
    total++; if (evt_vld !== 1 || evt_ch !== 3'd7)
      begin bad++; $display("FAIL rr_ptr7: got vld=%b ch=%0d want ch=7", evt_vld, evt_ch); end
    cycle();
    total++; if (evt_vld !== 1 || evt_ch !== 3'd0)
      begin bad++; $display("FAIL rr_wrap: got vld=%b ch=%0d want ch=0", evt_vld, evt_ch); end
    evt_rdy = 0;
  endtask

  task automatic test_collisions();
    do_reset();
    tick = 1; evt_rdy = 1;
    start(3, 2, 0); cycle();
    start_vld = 0; cycle();
    start(3, 3, 0); cycle();
    start_vld = 0;
    total++; if (timeout !== '0 || busy !== 8'h08)
      begin bad++; $display("FAIL start_vs_exp: got to=%h busy=%h want 00 08", timeout, busy); end
    cycle(); cycle();
    total++; if (timeout !== '0) begin bad++; $display("FAIL restart_early: got %h want 00", timeout); end
    cycle();
    total++; if (timeout !== 8'h08) begin bad++; $display("FAIL restart_count: got %h want 08", timeout); end
    cycle();
    total++; if (evt_vld !== 1 || evt_ch !== 3'd3)
      begin bad++; $display("FAIL restart_evt: got vld=%b ch=%0d want ch=3", evt_vld, evt_ch); end
    start(5, 1, 0); stop_vld = 1; stop_ch = 3'd5;
    cycle();
    start_vld = 0;
    total++; if (busy !== 8'h20) begin bad++; $display("FAIL start_vs_stop: got %h want 20", busy); end
    cycle();
    stop_vld = 0;
    total++; if (busy !== '0 || timeout !== '0)
      begin bad++; $display("FAIL stop_vs_exp: got busy=%h to=%h want 00 00", busy, timeout); end
    cycle();
    total++; if (evt_vld !== 0 || timeout !== '0)
      begin bad++; $display("FAIL stop_vs_exp_evt: got vld=%b to=%h want 0 00", evt_vld, timeout); end
    evt_rdy = 0;
    start(2, 2, 1); cycle();
    start_vld = 0;
    cycle(); cycle();
    total++; if (timeout !== 8'h04) begin bad++; $display("FAIL hs_first: got %h want 04", timeout); end
    cycle();
    evt_rdy = 1;
    cycle();
    evt_rdy = 0;
    total++; if (timeout !== 8'h04 || ovf !== '0)
      begin bad++; $display("FAIL hs_vs_exp: got to=%h ovf=%h want 04 00", timeout, ovf); end
    cycle();
    total++; if (evt_vld !== 1 || evt_ch !== 3'd2 || ovf !== '0)
      begin bad++; $display("FAIL hs_repend: got vld=%b ch=%0d ovf=%h want 1 2 00", evt_vld, evt_ch, ovf); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick = 1;
    start(5, 10, 0); cycle();
    start(2, 1, 0);  cycle();
    start_vld = 0;
    cycle();
    total++; if (timeout !== 8'h04) begin bad++; $display("FAIL rmid_pre: got %h want 04", timeout); end
    cycle();
    rst = 1;
    cycle();
    rst = 0;
    total++; if (busy !== '0 || timeout !== '0 || ovf !== '0 || evt_vld !== 0 || giveup !== '0)
      begin bad++; $display("FAIL rmid_clear: got busy=%h to=%h ovf=%h vld=%b gu=%h want all 0", busy, timeout, ovf, evt_vld, giveup); end
    for (int t = 0; t < 15; t++) begin
      cycle();
      total++; if (timeout !== '0 || evt_vld !== 0 || busy !== '0)
        begin bad++; $display("FAIL rmid_after t=%0d: got to=%h vld=%b busy=%h want 00 0 00", t, timeout, evt_vld, busy); end
    end
  endtask

  task automatic test_backoff();
    bit ex_to, ex_gu, ex_bz;
    do_reset();
    tick = 1; evt_rdy = 1;
    start(7, 4, 1); cycle();
    start_vld = 0;
    for (int t = 1; t <= 34; t++) begin
      cycle();
`ifdef TIMER_BACKOFF_EN
      ex_to = (t == 4 || t == 12 || t == 28);
      ex_gu = (t == 28);
      ex_bz = (t < 28);
`else
      ex_to = (t % 4 == 0);
      ex_gu = 0;
      ex_bz = 1;
`endif
      total++; if (timeout[7] !== ex_to || giveup[7] !== ex_gu || busy[7] !== ex_bz)
        begin bad++; $display("FAIL backoff t=%0d: got to=%b gu=%b busy=%b want %b %b %b", t, timeout[7], giveup[7], busy[7], ex_to, ex_gu, ex_bz); end
    end
    evt_rdy = 0;
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 399) == 0);
      tick      = ($urandom_range(0, 3) != 0);
      start_vld = ($urandom_range(0, 5) == 0);
      start_ch  = CHW'($urandom_range(0, N - 1));
      start_per = $urandom_range(0, 1);
      r         = $urandom_range(0, 9);
      start_val = (r == 0) ? '0 : (r < 8) ? W'($urandom_range(1, 6)) : W'($urandom_range(100, 255));
      stop_vld  = ($urandom_range(0, 11) == 0);
      stop_ch   = CHW'($urandom_range(0, N - 1));
      evt_rdy   = $urandom_range(0, 1);
      cycle();
      total++; if (busy !== m_busy)    begin bad++; $display("FAIL rnd_busy n=%0d: got %h want %h", n, busy, m_busy); end
      total++; if (timeout !== m_tmo)  begin bad++; $display("FAIL rnd_timeout n=%0d: got %h want %h", n, timeout, m_tmo); end
      total++; if (ovf !== m_ovf)      begin bad++; $display("FAIL rnd_ovf n=%0d: got %h want %h", n, ovf, m_ovf); end
      total++; if (giveup !== m_give)  begin bad++; $display("FAIL rnd_giveup n=%0d: got %h want %h", n, giveup, m_give); end
      total++; if (evt_vld !== m_evt_vld) begin bad++; $display("FAIL rnd_evt_vld n=%0d: got %b want %b", n, evt_vld, m_evt_vld); end
      if (m_evt_vld) begin
        total++; if (int'(evt_ch) != m_evt_ch) begin bad++; $display("FAIL rnd_evt_ch n=%0d: got %0d want %0d", n, evt_ch, m_evt_ch); end
      end
    end
    rst = 0; start_vld = 0; stop_vld = 0; evt_rdy = 0;
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic_ovf();
    test_round_robin();
    test_collisions();
    test_reset_mid();
    test_backoff();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
